tfm_pipe: RTL and testbench

Parametrised, multi-lane twiddle factor multiplier for the FFT datapath. It sits between the twiddle ROM/address generator and the butterfly stage. Per lane it computes the signed complex product of a data sample and a twiddle, optionally conjugating the twiddle (IFFT mode). Each output is rounded and saturated back to DATA_WIDTH, carried through a 3-stage elastic valid/ready pipeline that collapses bubbles.

---
 rtl/fft_pkg.sv | 38 +++
 rtl/tfm_lane.sv | 113 +++++++++++
 rtl/tfm_pipe.sv | 88 ++++++++
 tb/tb_tfm_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: rounding modes, twiddle format helper, saturation.
package fft_pkg;

    typedef enum logic {
        RND_TRUNC   = 1'b0,
        RND_HALF_UP = 1'b1
    } round_mode_e;

    typedef struct packed {
        logic signed [63:0] value;
        logic               flag;
    } sat_res_t;

    // Number of fractional bits in a Q2.x twiddle component.
    function automatic int tw_frac(input int tw_width);
        return tw_width - 2;
    endfunction

    // Clamp a signed value into a signed field of the given width; flag reports clamping.
    function automatic sat_res_t sat_signed(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t           r;
        hi      = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo      = -hi - 64'sd1;
        r.value = value;
        r.flag  = 1'b0;
        if (value > hi) begin
            r.value = hi;
            r.flag  = 1'b1;
        end else if (value < lo) begin
            r.value = lo;
            r.flag  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tfm_lane.sv
// One complex lane of the twiddle multiplier: S1 products, S2 sums, S3 round/shift/saturate.
module tfm_lane
    import fft_pkg::*;
#(
    parameter int DW         = 16,
    parameter int TW         = 18,
    parameter int ROUND_MODE = 1,
    parameter int SAT        = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld1,
    input  logic                 ld2,
    input  logic                 ld3,
    input  logic                 conj_s1,
    input  logic signed [DW-1:0] xr,
    input  logic signed [DW-1:0] xi,
    input  logic signed [TW-1:0] wr,
    input  logic signed [TW-1:0] wi,
    output logic        [DW-1:0] out_re,
    output logic        [DW-1:0] out_im,
    output logic                 out_sat
);

    localparam int PW = DW + TW;
    localparam int SW = PW + 1;
    localparam int TF = tw_frac(TW);
    localparam logic signed [SW-1:0] RND_K =
        (ROUND_MODE == int'(RND_HALF_UP)) ? (SW'(1) <<< (TF - 1)) : '0;

    logic signed [PW-1:0] p_rr_q, p_rr_d, p_ii_q, p_ii_d, p_ri_q, p_ri_d, p_ir_q, p_ir_d;
    logic signed [SW-1:0] s_re_q, s_re_d, s_im_q, s_im_d;
    logic signed [SW-1:0] re_rnd, im_rnd, re_sh, im_sh;
    logic        [DW-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
    logic                 out_sat_q, out_sat_d;
    sat_res_t             re_s, im_s;
    logic                 unused_hi_bits;

    // Next-state for all three datapath stages; each stage holds unless its load enable is set.
    always_comb begin
        p_rr_d    = p_rr_q;
        p_ii_d    = p_ii_q;
        p_ri_d    = p_ri_q;
        p_ir_d    = p_ir_q;
        s_re_d    = s_re_q;
        s_im_d    = s_im_q;
        out_re_d  = out_re_q;
        out_im_d  = out_im_q;
        out_sat_d = out_sat_q;

        // Conjugation flips the sign of the wi terms in the sums, so wi = -2^(TW-1) stays exact.
        re_rnd = s_re_q + RND_K;
        im_rnd = s_im_q + RND_K;
        re_sh  = re_rnd >>> TF;
        im_sh  = im_rnd >>> TF;
        re_s   = sat_signed(64'(re_sh), DW);
        im_s   = sat_signed(64'(im_sh), DW);

        if (ld1) begin
            p_rr_d = PW'(xr) * PW'(wr);
            p_ii_d = PW'(xi) * PW'(wi);
            p_ri_d = PW'(xr) * PW'(wi);
            p_ir_d = PW'(xi) * PW'(wr);
        end
        if (ld2) begin
            s_re_d = conj_s1 ? (SW'(p_rr_q) + SW'(p_ii_q)) : (SW'(p_rr_q) - SW'(p_ii_q));
            s_im_d = conj_s1 ? (SW'(p_ir_q) - SW'(p_ri_q)) : (SW'(p_ri_q) + SW'(p_ir_q));
        end
        if (ld3) begin
            if (SAT != 0) begin
                out_re_d  = re_s.value[DW-1:0];
                out_im_d  = im_s.value[DW-1:0];
                out_sat_d = re_s.flag | im_s.flag;
            end else begin
                out_re_d  = re_sh[DW-1:0];
                out_im_d  = im_sh[DW-1:0];
                out_sat_d = 1'b0;
            end
        end
    end

    assign unused_hi_bits = ^{re_s.value[63:DW], im_s.value[63:DW]};

    // Stage registers; reset clears everything so outputs read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_rr_q    <= '0;
            p_ii_q    <= '0;
            p_ri_q    <= '0;
            p_ir_q    <= '0;
            s_re_q    <= '0;
            s_im_q    <= '0;
            out_re_q  <= '0;
            out_im_q  <= '0;
            out_sat_q <= 1'b0;
        end else begin
            p_rr_q    <= p_rr_d;
            p_ii_q    <= p_ii_d;
            p_ri_q    <= p_ri_d;
            p_ir_q    <= p_ir_d;
            s_re_q    <= s_re_d;
            s_im_q    <= s_im_d;
            out_re_q  <= out_re_d;
            out_im_q  <= out_im_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign out_re  = out_re_q;
    assign out_im  = out_im_q;
    assign out_sat = out_sat_q;

endmodule

// File: rtl/tfm_pipe.sv
// Multi-lane twiddle factor multiplier: shared 3-stage elastic handshake over LANES datapaths.
module tfm_pipe
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TW_WIDTH   = 18,
    parameter int LANES      = 1,
    parameter int ROUND_MODE = 1,
    parameter int SAT        = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_conj,
    input  logic [LANES*DATA_WIDTH-1:0] in_re,
    input  logic [LANES*DATA_WIDTH-1:0] in_im,
    input  logic [LANES*TW_WIDTH-1:0]   tw_re,
    input  logic [LANES*TW_WIDTH-1:0]   tw_im,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_re,
    output logic [LANES*DATA_WIDTH-1:0] out_im,
    output logic [LANES-1:0]            out_sat
);

    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic conj1_q, conj1_d;
    logic ready_2, ready_3;
    logic ld1, ld2, ld3;

    // Handshake: a transfer happens on a rising edge where valid & ready are both high. Each
    // stage advances when it is empty or the stage after it advances, so bubbles collapse and
    // a full pipe still accepts input in the same cycle the output is taken.
    always_comb begin
        ready_3  = ~v3_q | out_ready;
        ready_2  = ~v2_q | ready_3;
        in_ready = ~v1_q | ready_2;
        ld1      = in_valid & in_ready;
        ld2      = v1_q & ready_2;
        ld3      = v2_q & ready_3;
        v1_d     = in_ready ? in_valid : v1_q;
        v2_d     = ready_2 ? v1_q : v2_q;
        v3_d     = ready_3 ? v2_q : v3_q;
        conj1_d  = ld1 ? in_conj : conj1_q;
    end

    // Stage valid bits and the conj flag that travels alongside the S1 products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            conj1_q <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            conj1_q <= conj1_d;
        end
    end

    assign out_valid = v3_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        tfm_lane #(
            .DW        (DATA_WIDTH),
            .TW        (TW_WIDTH),
            .ROUND_MODE(ROUND_MODE),
            .SAT       (SAT)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .ld1    (ld1),
            .ld2    (ld2),
            .ld3    (ld3),
            .conj_s1(conj1_q),
            .xr     (in_re[k*DATA_WIDTH +: DATA_WIDTH]),
            .xi     (in_im[k*DATA_WIDTH +: DATA_WIDTH]),
            .wr     (tw_re[k*TW_WIDTH +: TW_WIDTH]),
            .wi     (tw_im[k*TW_WIDTH +: TW_WIDTH]),
            .out_re (out_re[k*DATA_WIDTH +: DATA_WIDTH]),
            .out_im (out_im[k*DATA_WIDTH +: DATA_WIDTH]),
            .out_sat(out_sat[k])
        );
    end

endmodule

// File: tb/tb_tfm_pipe.sv
// Bench for tfm_pipe: two 4-lane instances (round+saturate, truncate+wrap) on shared stimulus.
module tb_tfm_pipe;

    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int TW    = 18;
    localparam int RW    = 2*LANES*DW + LANES;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                  in_valid, in_conj, out_ready;
    logic [LANES*DW-1:0]   in_re, in_im;
    logic [LANES*TW-1:0]   tw_re, tw_im;
    logic                  in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [LANES*DW-1:0]   out_re_a, out_im_a, out_re_b, out_im_b;
    logic [LANES-1:0]      out_sat_a, out_sat_b;

    tfm_pipe #(.DATA_WIDTH(DW), .TW_WIDTH(TW), .LANES(LANES), .ROUND_MODE(1), .SAT(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_conj(in_conj),
        .in_re(in_re), .in_im(in_im), .tw_re(tw_re), .tw_im(tw_im),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_re(out_re_a), .out_im(out_im_a), .out_sat(out_sat_a)
    );

    tfm_pipe #(.DATA_WIDTH(DW), .TW_WIDTH(TW), .LANES(LANES), .ROUND_MODE(0), .SAT(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_conj(in_conj),
        .in_re(in_re), .in_im(in_im), .tw_re(tw_re), .tw_im(tw_im),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_re(out_re_b), .out_im(out_im_b), .out_sat(out_sat_b)
    );

    // ---------------- scoreboard ----------------
    logic [RW-1:0] exp_a_q[$];
    logic [RW-1:0] exp_b_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic          acc_last;
    logic          hold_vld;
    logic [RW-1:0] hold_a;

    task automatic check_eq(input string tag, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Round/shift one component by the Q2.16 fraction, then clamp or wrap to 16 bits.
    function automatic void fix(input longint v, input bit rnd, input bit sat,
                                output logic [15:0] r, output logic f);
        longint t;
        t = v + (rnd ? 32768 : 0);
        t = t >>> 16;
        f = 1'b0;
        if (sat && t > 32767) begin
            r = 16'h7fff;
            f = 1'b1;
        end else if (sat && t < -32768) begin
            r = 16'h8000;
            f = 1'b1;
        end else begin
            r = t[15:0];
        end
    endfunction

    function automatic logic [RW-1:0] model(input bit rnd, input bit sat);
        logic [LANES*DW-1:0] re_v, im_v;
        logic [LANES-1:0]    s_v;
        for (int k = 0; k < LANES; k++) begin
            longint xr, xi, wr, wi, pr, pi;
            logic [15:0] rr, ri;
            logic fr, fi;
            xr = longint'($signed(in_re[k*DW +: DW]));
            xi = longint'($signed(in_im[k*DW +: DW]));
            wr = longint'($signed(tw_re[k*TW +: TW]));
            wi = longint'($signed(tw_im[k*TW +: TW]));
            if (in_conj) begin
                pr = xr*wr + xi*wi;
                pi = xi*wr - xr*wi;
            end else begin
                pr = xr*wr - xi*wi;
                pi = xr*wi + xi*wr;
            end
            fix(pr, rnd, sat, rr, fr);
            fix(pi, rnd, sat, ri, fi);
            re_v[k*DW +: DW] = rr;
            im_v[k*DW +: DW] = ri;
            s_v[k]           = fr | fi;
        end
        return {re_v, im_v, s_v};
    endfunction

    // One cycle: inputs already set at the falling edge; observe, score, then move to next fall.
    task automatic step();
        logic [RW-1:0] act_a, act_b, e;
        #1;
        acc_last = 1'b0;
        if (!rst) begin
            act_a = {out_re_a, out_im_a, out_sat_a};
            act_b = {out_re_b, out_im_b, out_sat_b};
            check_eq("in_ready_a", RW'(in_ready_a), RW'(!(exp_a_q.size() == 3 && !out_ready)));
            check_eq("in_ready_b", RW'(in_ready_b), RW'(!(exp_b_q.size() == 3 && !out_ready)));
            if (hold_vld) check_eq("stall_hold", act_a, hold_a);
            hold_vld = out_valid_a && !out_ready;
            hold_a   = act_a;
            if (out_valid_a && out_ready) begin
                if (exp_a_q.size() == 0) check_eq("spurious_a", RW'(1), RW'(0));
                else begin
                    e = exp_a_q.pop_front();
                    check_eq("out_a", act_a, e);
                end
            end
            if (out_valid_b && out_ready) begin
                if (exp_b_q.size() == 0) check_eq("spurious_b", RW'(1), RW'(0));
                else begin
                    e = exp_b_q.pop_front();
                    check_eq("out_b", act_b, e);
                end
            end
            if (in_valid && in_ready_a) begin
                exp_a_q.push_back(model(1'b1, 1'b1));
                exp_b_q.push_back(model(1'b0, 1'b0));
                acc_last = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [TW-1:0] rand_tw();
        case ($urandom_range(0, 7))
            0:       return 18'h20000;
            1:       return 18'h10000;
            2:       return 18'h1ffff;
            default: return TW'($urandom_range(0, (1 << TW) - 1));
        endcase
    endfunction

    task automatic rand_inputs();
        for (int k = 0; k < LANES; k++) begin
            in_re[k*DW +: DW] = DW'($urandom);
            in_im[k*DW +: DW] = DW'($urandom);
            tw_re[k*TW +: TW] = rand_tw();
            tw_im[k*TW +: TW] = rand_tw();
        end
        in_conj = 1'($urandom_range(0, 1));
    endtask

    // Single transfer with lane 0 fixed; checks latency and lane 0 against hand-derived values.
    task automatic directed(input string tag, input int xr, input int xi, input int wr,
                            input int wi, input logic conj, input int re_a, input int im_a,
                            input logic sat_a, input int re_b, input int im_b);
        int lat;
        rand_inputs();
        in_re[15:0] = xr[15:0];
        in_im[15:0] = xi[15:0];
        tw_re[17:0] = wr[17:0];
        tw_im[17:0] = wi[17:0];
        in_conj   = conj;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid_a && lat < 8) begin
            step();
            lat++;
        end
        check_eq({tag, "_lat"}, RW'(lat), RW'(3));
        check_eq({tag, "_re_a"}, RW'(out_re_a[15:0]), RW'(re_a[15:0]));
        check_eq({tag, "_im_a"}, RW'(out_im_a[15:0]), RW'(im_a[15:0]));
        check_eq({tag, "_sat_a"}, RW'(out_sat_a[0]), RW'(sat_a));
        check_eq({tag, "_re_b"}, RW'(out_re_b[15:0]), RW'(re_b[15:0]));
        check_eq({tag, "_im_b"}, RW'(out_im_b[15:0]), RW'(im_b[15:0]));
        check_eq({tag, "_sat_b"}, RW'(out_sat_b[0]), RW'(0));
        step();
    endtask

    task automatic stream(input string tag, input int n_xfer, input int rdy_pct);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < n_xfer && cyc < 400) begin
            in_valid  = ($urandom_range(0, 99) < 80);
            rand_inputs();
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            step();
            if (acc_last) got++;
            cyc++;
        end
        check_eq({tag, "_xfers"}, RW'(got), RW'(n_xfer));
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && cyc < 20) begin
            step();
            cyc++;
        end
        check_eq({tag, "_drain_a"}, RW'(exp_a_q.size()), RW'(0));
        check_eq({tag, "_drain_b"}, RW'(exp_b_q.size()), RW'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_conj   = 1'b0;
        out_ready = 1'b0;
        in_re     = '0;
        in_im     = '0;
        tw_re     = '0;
        tw_im     = '0;
        hold_vld  = 1'b0;
        hold_a    = '0;
        acc_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", RW'(out_valid_a | out_valid_b), RW'(0));
        check_eq("rst_out_a", {out_re_a, out_im_a, out_sat_a}, '0);
        check_eq("rst_out_b", {out_re_b, out_im_b, out_sat_b}, '0);
        rst = 1'b0;

        directed("ident", 1000, -2000, 'h10000, 0, 1'b0, 1000, -2000, 1'b0, 1000, -2000);
        directed("rot_j", 1000, -2000, 0, 'h10000, 1'b0, 2000, 1000, 1'b0, 2000, 1000);
        directed("rot_conj", 1000, -2000, 0, 'h10000, 1'b1, -2000, -1000, 1'b0, -2000, -1000);
        directed("rnd_pos", 3, 0, 'h08000, 0, 1'b0, 2, 0, 1'b0, 1, 0);
        directed("rnd_neg", -3, 0, 'h08000, 0, 1'b0, -1, 0, 1'b0, -2, 0);
        directed("sat", -32768, -32768, 'h10000, 'h10000, 1'b0, 0, -32768, 1'b1, 0, 0);

        stream("full_rate", 12, 100);
        drain("full_rate");
        stream("bp", 30, 50);
        drain("bp");

        // Fill with the output stalled: in_ready must fall only once three items are held.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            rand_inputs();
            step();
        end
        check_eq("fill_count", RW'(exp_a_q.size()), RW'(3));

        // Asynchronous reset between edges with a full pipe.
        #3 rst = 1'b1;
        #1;
        check_eq("arst_valid", RW'(out_valid_a | out_valid_b), RW'(0));
        check_eq("arst_out_a", {out_re_a, out_im_a, out_sat_a}, '0);
        check_eq("arst_out_b", {out_re_b, out_im_b, out_sat_b}, '0);
        exp_a_q.delete();
        exp_b_q.delete();
        hold_vld = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", RW'(in_ready_a & in_ready_b), RW'(1));
        @(negedge clk);

        stream("post_rst", 15, 60);
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation limit reached");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
